actlow_encoder: RTL and testbench

Registered 4-to-2 encoder for active-low one-of-four select lines: the receiving end of the team's active-low 2-to-4 decoder path. It samples four active-low request lines, requires a pattern to be stable before accepting it, encodes the selected line to a 2-bit code, and holds that code under a valid/ack handshake until the consumer takes it. It sits between decoder-driven select buses, or external active-low strobes, and the downstream control logic.

---
 rtl/actlow_pkg.sv | 19 +
 rtl/actlow_encoder_if.sv | 27 ++
 rtl/actlow_pick4.sv | 31 +++
 rtl/actlow_encoder.sv | 126 ++++++++++++
 tb/tb_actlow_encoder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/actlow_pkg.sv
// Shared types and helpers for the active-low one-of-four encoder.
// Holds the FSM state encoding, line/index widths and the popcount helper.
package actlow_pkg;

  localparam int NLINES = 4;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  function automatic logic [2:0] popcount4(input logic [NLINES-1:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/actlow_encoder_if.sv
// Request/code bus of the active-low encoder: request lines in, held code out under valid/ack.
// The encoder uses the slave modport; the driver of d_n/ack and consumer of the code use master.
interface actlow_encoder_if;

  logic [actlow_pkg::NLINES-1:0] d_n;
  logic [actlow_pkg::IDX_W-1:0]  s;
  logic                          valid;
  logic                          ack;
  logic                          multi;

  modport slave (
    input  d_n,
    input  ack,
    output s,
    output valid,
    output multi
  );

  modport master (
    output d_n,
    output ack,
    input  s,
    input  valid,
    input  multi
  );

endinterface

// File: rtl/actlow_pick4.sv
// Combinational 4-line picker: first active bit searching from i_start, no latency, no backpressure.
// ACTLOW_ENC_RR_EN: ascending modulo-4 search; otherwise descending (start tied to 3 = fixed priority).
module actlow_pick4
  import actlow_pkg::*;
(
  input  logic [NLINES-1:0] i_pat,
  input  logic [IDX_W-1:0]  i_start,
  output logic [IDX_W-1:0]  o_idx
);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NLINES; k++) begin
`ifdef ACTLOW_ENC_RR_EN
      w_cand = i_start + IDX_W'(k);
`else
      w_cand = i_start - IDX_W'(k);
`endif
      if (!w_found && i_pat[w_cand]) begin
        o_idx   = w_cand;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/actlow_encoder.sv
// Registered 4-to-2 encoder for active-low requests; valid STABLE_CYCLES edges after d_q sees a pattern.
// Code held frozen with valid until ack; ACTLOW_ENC_RR_EN selects round-robin instead of fixed priority.
module actlow_encoder
  import actlow_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  actlow_encoder_if.slave   bus
);

  localparam logic [4:0] STABLE_W = 5'(STABLE_CYCLES);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15) begin : g_bad_stable
    $error("actlow_encoder: STABLE_CYCLES must be within 1..15");
  end

  logic [NLINES-1:0] r_d_q;
  logic [NLINES-1:0] r_pat;
  logic [3:0]        r_cnt;
  state_t            r_state;
  logic [IDX_W-1:0]  r_s;
  logic              r_valid;
  logic              r_multi;

  logic [NLINES-1:0] w_act;
  logic [IDX_W-1:0]  w_start;
  logic [IDX_W-1:0]  w_pick;
  logic              w_capture;

  assign w_act = ~r_d_q;

`ifdef ACTLOW_ENC_RR_EN
  logic [IDX_W-1:0] r_last;
  assign w_start = r_last + 2'd1;
`else
  assign w_start = IDX_W'(NLINES - 1);
`endif

  actlow_pick4 u_pick (
    .i_pat   (w_act),
    .i_start (w_start),
    .o_idx   (w_pick)
  );

  // Capture once the current sample completes the required run of identical samples.
  always_comb begin
    w_capture = 1'b0;
    case (r_state)
      IDLE:    w_capture = (w_act != '0) && (STABLE_CYCLES == 1);
      QUALIFY: w_capture = (w_act == r_pat) && (({1'b0, r_cnt} + 5'd1) >= STABLE_W);
      default: w_capture = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d_q   <= '1;
      r_pat   <= '0;
      r_cnt   <= '0;
      r_state <= IDLE;
      r_s     <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
`ifdef ACTLOW_ENC_RR_EN
      r_last  <= 2'b11;
`endif
    end else begin
      r_d_q <= bus.d_n;
      if (w_capture) begin
        r_pat   <= w_act;
        r_cnt   <= '0;
        r_s     <= w_pick;
        r_multi <= (popcount4(w_act) > 3'd1);
        r_valid <= 1'b1;
        r_state <= HOLD;
`ifdef ACTLOW_ENC_RR_EN
        r_last  <= w_pick;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (w_act != '0) begin
              r_pat   <= w_act;
              r_cnt   <= 4'd1;
              r_state <= QUALIFY;
            end
          end
          QUALIFY: begin
            if (w_act == r_pat) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (w_act != '0) begin
              r_pat <= w_act;
              r_cnt <= 4'd1;
            end else begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end
          end
          HOLD: begin
            if (bus.ack) begin
              r_valid <= 1'b0;
              r_state <= RELEASE;
            end
          end
          RELEASE: begin
            // Only the captured line must be released; other held lines re-qualify from IDLE.
            if (r_d_q[r_s]) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.s     = r_s;
  assign bus.valid = r_valid;
  assign bus.multi = r_multi;

  a_hold_frozen: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == HOLD && !bus.ack) |=> (r_valid && $stable(r_s) && $stable(r_multi)));

endmodule

// File: tb/tb_actlow_encoder.sv
// Bench for actlow_encoder: directed test-plan scenarios, then random requests/acks/resets
// checked every cycle against a run-length reference model.
module tb_actlow_encoder;

  localparam int STABLE = 2;
`ifdef ACTLOW_ENC_RR_EN
  localparam int EXP_ALL_S  = 0;
  localparam int EXP_REP_S  = 0;
`else
  localparam int EXP_ALL_S  = 3;
  localparam int EXP_REP_S  = 3;
`endif

  logic clk = 1'b0;
  logic rst_n;

  actlow_encoder_if enc_if ();

  actlow_encoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (enc_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a request is accepted once the same nonzero pattern has
  // been seen on STABLE consecutive registered samples while waiting.
  typedef enum {M_WAIT, M_HOLD, M_REL} mphase_t;
  mphase_t    m_phase = M_WAIT;
  logic [3:0] m_hist  = 4'hF;
  logic [3:0] m_prev  = 4'h0;
  int         m_run   = 0;
  int         m_s     = 0;
  int         m_last  = 3;
  logic       m_valid = 1'b0;
  logic       m_multi = 1'b0;

  function automatic int ref_pick(input logic [3:0] a, input int last);
`ifdef ACTLOW_ENC_RR_EN
    for (int k = 1; k <= 4; k++)
      if (a[(last + k) % 4]) return (last + k) % 4;
`else
    for (int i = 3; i >= 0; i--)
      if (a[i]) return i;
`endif
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [3:0] act;
    act = ~m_hist;
    if (!rst_n) begin
      m_phase = M_WAIT;
      m_hist  = 4'hF;
      m_run   = 0;
      m_s     = 0;
      m_last  = 3;
      m_valid = 1'b0;
      m_multi = 1'b0;
    end else begin
      case (m_phase)
        M_WAIT: begin
          if (act == 4'h0) m_run = 0;
          else if (m_run > 0 && act == m_prev) m_run++;
          else m_run = 1;
          m_prev = act;
          if (m_run >= STABLE) begin
            m_s     = ref_pick(act, m_last);
            m_last  = m_s;
            m_multi = ($countones(act) > 1);
            m_valid = 1'b1;
            m_phase = M_HOLD;
            m_run   = 0;
          end
        end
        M_HOLD: if (enc_if.ack) begin
          m_valid = 1'b0;
          m_phase = M_REL;
        end
        default: if (m_hist[m_s]) m_phase = M_WAIT;
      endcase
      m_hist = enc_if.d_n;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check_eq("s", int'(enc_if.s), m_s);
      check_eq("valid", int'(enc_if.valid), int'(m_valid));
      check_eq("multi", int'(enc_if.multi), int'(m_multi));
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (enc_if.valid !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    check_eq("vld_seen", int'(enc_if.valid), 1);
  endtask

  task automatic release_all();
    enc_if.d_n = 4'hF;
    enc_if.ack = 1'b1;
    step(1);
    enc_if.ack = 1'b0;
    step(3);
  endtask

  initial begin
    int n;
    int hold_left;
    logic [3:0] p;
    rst_n      = 1'b0;
    enc_if.d_n = 4'h0;
    enc_if.ack = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("rst_valid", int'(enc_if.valid), 0);
      check_eq("rst_s", int'(enc_if.s), 0);
      check_eq("rst_multi", int'(enc_if.multi), 0);
    end
    rst_n = 1'b1;
    wait_valid(n);
    check_eq("rst_lat", n, 3);
    check_eq("all_s", int'(enc_if.s), EXP_ALL_S);
    check_eq("all_multi", int'(enc_if.multi), 1);
    release_all();

    enc_if.d_n = 4'b1011;
    wait_valid(n);
    check_eq("l2_lat", n, 3);
    step(2);
    check_eq("l2_s", int'(enc_if.s), 2);
    check_eq("l2_multi", int'(enc_if.multi), 0);
    enc_if.ack = 1'b1;
    step(1);
    enc_if.ack = 1'b0;
    check_eq("ack_drop", int'(enc_if.valid), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("rel_low", int'(enc_if.valid), 0);
    end
    enc_if.d_n = 4'hF;
    step(3);

    enc_if.d_n = 4'b0110;
    wait_valid(n);
    check_eq("p03_s", int'(enc_if.s), 3);
    check_eq("p03_multi", int'(enc_if.multi), 1);
    release_all();
    enc_if.d_n = 4'b0110;
    wait_valid(n);
    check_eq("p03_rep_s", int'(enc_if.s), EXP_REP_S);
    check_eq("p03_rep_multi", int'(enc_if.multi), 1);
    release_all();

    enc_if.d_n = 4'b1101;
    step(1);
    enc_if.d_n = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check_eq("glitch", int'(enc_if.valid), 0);
    end
    enc_if.d_n = 4'b1110;
    step(1);
    enc_if.d_n = 4'b1101;
    wait_valid(n);
    check_eq("restart_lat", n, 3);
    check_eq("restart_s", int'(enc_if.s), 1);
    check_eq("restart_multi", int'(enc_if.multi), 0);

    enc_if.d_n = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("hold_s", int'(enc_if.s), 1);
      check_eq("hold_multi", int'(enc_if.multi), 0);
      check_eq("hold_valid", int'(enc_if.valid), 1);
    end
    rst_n = 1'b0;
    step(1);
    check_eq("rst_hold", int'(enc_if.valid), 0);
    rst_n      = 1'b1;
    enc_if.d_n = 4'hF;
    step(3);

    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: enc_if.d_n = 4'hF;
          4, 5, 6, 7: begin
            p = 4'b0001 << $urandom_range(0, 3);
            enc_if.d_n = ~p;
          end
          default: enc_if.d_n = 4'($urandom);
        endcase
        hold_left = int'($urandom_range(1, 6));
      end
      hold_left--;
      enc_if.ack = ($urandom_range(0, 3) == 0);
      rst_n      = ($urandom_range(0, 299) != 0);
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
